// File: rtl/trap_unit_pipe.sv
// trap_unit_pipe: PowerPC trap-condition evaluator (tw/twi/td/tdi) behind an
// elastic pipeline of STAGES entries with speculative flush.
// The compare runs on stage-0 operands and only the result travels further.
// Optional: define TRAP_UNIT_CAUSE_EN to add the trap_cause[0:4] output.
module trap_unit_pipe #(
    parameter int RS_ID_WIDTH = 5,
    parameter int XLEN        = 32,
    parameter int STAGES      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [RS_ID_WIDTH-1:0] rs_id_in,
    input  logic [XLEN-1:0]        op1,
    input  logic [XLEN-1:0]        op2,
    input  logic [0:4]             to,
    input  logic                   word_mode,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [RS_ID_WIDTH-1:0] rs_id_out,
    output logic                   trap
`ifdef TRAP_UNIT_CAUSE_EN
    ,
    output logic [0:4]             trap_cause
`endif
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("trap_unit_pipe: XLEN must be 32 or 64");
    end
    if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
        $error("trap_unit_pipe: STAGES must be in 1..8");
    end

    // First stage that holds a compare result instead of operands.
    localparam int T0 = (STAGES == 1) ? 0 : 1;
`ifdef TRAP_UNIT_CAUSE_EN
    localparam int RW = 5;
`else
    localparam int RW = 1;
`endif

    // Per-condition matches (cond & to); MSB-first: [0]=lt s, [1]=gt s, [2]=eq, [3]=lt u, [4]=gt u.
    // Operands are widened by one bit so signed and unsigned compares share a form.
    function automatic logic [0:4] trap_match(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                              input logic [0:4] t, input logic wm);
        logic [XLEN:0] as_x, bs_x, au_x, bu_x;
        logic slt, sgt, ult, ugt, eq;
        if (XLEN == 64 && wm) begin
            as_x = {{(XLEN-31){a[31]}}, a[31:0]};
            bs_x = {{(XLEN-31){b[31]}}, b[31:0]};
            au_x = {{(XLEN-31){1'b0}}, a[31:0]};
            bu_x = {{(XLEN-31){1'b0}}, b[31:0]};
        end else begin
            as_x = {a[XLEN-1], a};
            bs_x = {b[XLEN-1], b};
            au_x = {1'b0, a};
            bu_x = {1'b0, b};
        end
        slt = $signed(as_x) < $signed(bs_x);
        sgt = $signed(as_x) > $signed(bs_x);
        ult = au_x < bu_x;
        ugt = au_x > bu_x;
        eq  = au_x == bu_x;
        return {slt & t[0], sgt & t[1], eq & t[2], ult & t[3], ugt & t[4]};
    endfunction

    logic                   v       [STAGES];
    logic [RS_ID_WIDTH-1:0] tag     [STAGES];
    logic                   src_v   [STAGES];
    logic [RS_ID_WIDTH-1:0] src_tag [STAGES];
    logic [RW-1:0]          res_q   [T0:STAGES-1];
    logic [RW-1:0]          src_res [T0:STAGES-1];
    logic [STAGES-1:0]      en;
    logic [0:4]             match;
    logic [RW-1:0]          res;

    // Stage k may advance if any stage from k to the output is empty or the
    // consumer takes the head; bubbles therefore collapse.
    always_comb begin
        logic acc;
        acc = output_ready;
        en  = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc   = acc | ~v[k];
            en[k] = acc;
        end
    end

    assign input_ready = en[0] & ~flush;

    if (STAGES == 1) begin : g_cmp_in
        assign match = trap_match(op1, op2, to, word_mode);
    end else begin : g_cmp_s0
        logic [XLEN-1:0] a_q, b_q;
        logic [0:4]      to_q;
        logic            wm_q;
        // Stage-0 operand payload, captured alongside the stage-0 tag.
        always_ff @(posedge clk) begin
            if (rst) begin
                a_q  <= '0;
                b_q  <= '0;
                to_q <= '0;
                wm_q <= 1'b0;
            end else if (en[0]) begin
                a_q  <= op1;
                b_q  <= op2;
                to_q <= to;
                wm_q <= word_mode;
            end
        end
        assign match = trap_match(a_q, b_q, to_q, wm_q);
    end

`ifdef TRAP_UNIT_CAUSE_EN
    assign res = match;
`else
    assign res = |match;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_src
            assign src_v[k]   = input_valid;
            assign src_tag[k] = rs_id_in;
        end else begin : g_src
            assign src_v[k]   = v[k-1];
            assign src_tag[k] = tag[k-1];
        end

        // Valid and tag advance on enable; flush empties the stage.
        always_ff @(posedge clk) begin
            if (rst) begin
                v[k]   <= 1'b0;
                tag[k] <= '0;
            end else if (flush) begin
                v[k]   <= 1'b0;
            end else if (en[k]) begin
                v[k]   <= src_v[k];
                tag[k] <= src_tag[k];
            end
        end

        if (k == T0) begin : g_res
            assign src_res[k] = res;
        end else if (k > T0) begin : g_res
            assign src_res[k] = res_q[k-1];
        end

        if (k >= T0) begin : g_resq
            // Compare result rides along with the valid/tag of its stage.
            always_ff @(posedge clk) begin
                if (rst) res_q[k] <= '0;
                else if (en[k]) res_q[k] <= src_res[k];
            end
        end
    end

    assign output_valid = v[STAGES-1];
    assign rs_id_out    = tag[STAGES-1];
    assign trap         = |res_q[STAGES-1];
`ifdef TRAP_UNIT_CAUSE_EN
    assign trap_cause   = res_q[STAGES-1];
`endif

endmodule

// File: tb/tb_trap_unit_pipe.sv
// Scoreboard bench for trap_unit_pipe: stimulus pushes expected results from a
// behavioural model; a monitor pops and compares on each output handshake.
module tb_trap_unit_pipe;
    localparam int RSW = 5;
    localparam int XL  = 64;
    localparam int ST  = 3;

    logic           clk = 1'b0;
    logic           rst, flush, input_valid, input_ready, word_mode;
    logic           output_valid, trap;
    logic           output_ready = 1'b1;
    logic [RSW-1:0] rs_id_in, rs_id_out;
    logic [XL-1:0]  op1, op2;
    logic [0:4]     to;
`ifdef TRAP_UNIT_CAUSE_EN
    logic [0:4]     trap_cause;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int or_mode = 1;   // 0 = hold low, 1 = hold high, 2 = random back-pressure

    typedef struct packed {
        logic [RSW-1:0] tag;
        logic [0:4]     cause;
    } exp_t;
    exp_t sbq[$];

    trap_unit_pipe #(.RS_ID_WIDTH(RSW), .XLEN(XL), .STAGES(ST)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .input_valid(input_valid), .input_ready(input_ready),
        .rs_id_in(rs_id_in), .op1(op1), .op2(op2), .to(to), .word_mode(word_mode),
        .output_valid(output_valid), .output_ready(output_ready),
        .rs_id_out(rs_id_out), .trap(trap)
`ifdef TRAP_UNIT_CAUSE_EN
        , .trap_cause(trap_cause)
`endif
    );

    always #5 clk = ~clk;

    // Reference: compare as 64-bit integers, or as 32-bit words in word mode.
    function automatic logic [0:4] model(input logic [63:0] a, input logic [63:0] b,
                                         input logic [0:4] t, input logic wm);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [0:4]      c;
        if (wm) begin
            sa = longint'($signed(a[31:0]));
            sb = longint'($signed(b[31:0]));
            ua = {32'd0, a[31:0]};
            ub = {32'd0, b[31:0]};
        end else begin
            sa = $signed(a);
            sb = $signed(b);
            ua = a;
            ub = b;
        end
        c[0] = t[0] && (sa < sb);
        c[1] = t[1] && (sa > sb);
        c[2] = t[2] && (ua == ub);
        c[3] = t[3] && (ua < ub);
        c[4] = t[4] && (ua > ub);
        return c;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rnd_op(input logic [63:0] other);
        int s;
        case ($urandom_range(0, 3))
            0: return other;
            1: return {$urandom(), other[31:0]};
            2: begin
                s = int'($urandom_range(0, 8)) - 4;
                return longint'(s);
            end
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // Consumer back-pressure, updated shortly after each active edge.
    always @(posedge clk) begin
        #2;
        case (or_mode)
            0: output_ready = 1'b0;
            1: output_ready = 1'b1;
            default: output_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Output monitor: stall stability, then in-order pop on handshake.
    logic           prev_stall = 1'b0;
    logic [RSW-1:0] prev_tag;
    logic           prev_trap;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sbq.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", output_valid, 1);
                chk("stall_tag", rs_id_out, prev_tag);
                chk("stall_trap", trap, prev_trap);
            end
            prev_stall = output_valid && !output_ready;
            prev_tag   = rs_id_out;
            prev_trap  = trap;
            if (output_valid && output_ready) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: tag=%0d appeared with empty scoreboard", rs_id_out);
                end else begin
                    e = sbq.pop_front();
                    chk("out_tag", rs_id_out, e.tag);
                    chk("out_trap", trap, |e.cause);
`ifdef TRAP_UNIT_CAUSE_EN
                    chk("out_cause", trap_cause, e.cause);
`endif
                end
            end
            if (flush) begin
                sbq.delete();
                prev_stall = 1'b0;
            end
        end
    end

    // Offer one op (called just after an active edge) until accepted.
    task automatic drive_op(input logic [RSW-1:0] tg, input logic [63:0] a, input logic [63:0] b,
                            input logic [0:4] t, input logic wm);
        bit   done;
        int   w;
        exp_t e;
        done = 0;
        w = 0;
        rs_id_in = tg; op1 = a; op2 = b; to = t; word_mode = wm; input_valid = 1'b1;
        while (!done && w < 100) begin
            @(negedge clk);
            if (input_ready) begin
                e.tag = tg;
                e.cause = model(a, b, t, wm);
                sbq.push_back(e);
                done = 1;
            end
            @(posedge clk); #1;
            w++;
        end
        input_valid = 1'b0;
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: tag %0d not accepted within 100 cycles", tg);
        end
    endtask

    task automatic drive_rnd(input logic [RSW-1:0] tg);
        logic [63:0] a;
        a = {$urandom(), $urandom()};
        drive_op(tg, a, rnd_op(a), 5'($urandom()), 1'($urandom()));
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (sbq.size() != 0 && w < 500) begin
            @(posedge clk); #1;
            w++;
        end
        if (sbq.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results still pending", sbq.size());
        end
    endtask

    initial begin
        int   lat, acc;
        exp_t e;
        rst = 1'b1; flush = 1'b0; input_valid = 1'b0; rs_id_in = '0;
        op1 = '0; op2 = '0; to = '0; word_mode = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", output_valid, 0);
        chk("reset_rs_id_out", rs_id_out, 0);
        chk("reset_trap", trap, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_input_ready", input_ready, 1);
        @(posedge clk); #1;

        // Latency and basic compares (-1 < 1 signed; lt-unsigned does not match).
        drive_op(5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 5'b10000, 1'b0);
        @(negedge clk);
        lat = 1;
        while (!output_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, ST);
        @(posedge clk); #1;
        drive_op(5'd2, 64'h0000_0000_FFFF_FFFF, 64'h1, 5'b10000, 1'b1);
        drive_op(5'd3, 64'h0000_0000_FFFF_FFFF, 64'h1, 5'b00010, 1'b1);
        drive_op(5'd4, 64'h0000_0001_0000_0005, 64'h0000_0002_0000_0005, 5'b00100, 1'b1);
        drive_op(5'd5, 64'h0000_0001_0000_0005, 64'h0000_0002_0000_0005, 5'b00100, 1'b0);
        drive_op(5'd6, 64'h10, 64'h10, 5'b11111, 1'b0);
        drive_op(5'd7, 64'h10, 64'h3, 5'b00000, 1'b0);
        wait_drain();

        // Fill under stall: only ST ops fit, then release and drain in order.
        or_mode = 0;
        @(posedge clk); #1;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            rs_id_in = RSW'(acc + 1);
            op1 = {$urandom(), $urandom()};
            op2 = rnd_op(op1);
            to = 5'($urandom());
            word_mode = 1'($urandom());
            input_valid = 1'b1;
            @(negedge clk);
            if (input_ready) begin
                e.tag = rs_id_in;
                e.cause = model(op1, op2, to, word_mode);
                sbq.push_back(e);
                acc++;
            end
            @(posedge clk); #1;
        end
        input_valid = 1'b0;
        chk("fill_accepts", acc, ST);
        @(negedge clk);
        chk("full_input_ready", input_ready, 0);
        chk("full_out_valid", output_valid, 1);
        @(posedge clk); #1;
        or_mode = 1;
        for (int tg = acc + 1; tg <= 6; tg++) drive_rnd(RSW'(tg));
        wait_drain();

        // Flush while holding 7,8 and offering 9.
        or_mode = 0;
        @(posedge clk); #1;
        drive_rnd(5'd7);
        drive_rnd(5'd8);
        repeat (2) begin @(posedge clk); #1; end
        flush = 1'b1; input_valid = 1'b1; rs_id_in = 5'd9;
        @(negedge clk);
        chk("flush_input_ready", input_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0; input_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", output_valid, 0);
        @(posedge clk); #1;
        or_mode = 1;
        repeat (6) begin @(posedge clk); #1; end

        // Reset mid-stream with two trapping entries in flight.
        or_mode = 0;
        @(posedge clk); #1;
        drive_op(5'd10, 64'h1, 64'h2, 5'b11111, 1'b0);
        drive_op(5'd11, 64'h5, 64'h5, 5'b11111, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", output_valid, 0);
        chk("midrst_trap", trap, 0);
        chk("midrst_rs_id_out", rs_id_out, 0);
        chk("midrst_input_ready", input_ready, 1);
        @(posedge clk); #1;

        // Random stream with back-pressure and occasional flushes.
        or_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
                @(posedge clk); #1;
            end else begin
                drive_rnd(RSW'($urandom()));
            end
        end
        or_mode = 1;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, %0d checks, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
